seq_stream_ctrl: RTL and testbench
==================================

Name: seq_stream_ctrl

Overview:
Stream controller that sequences a programmable serial pattern matcher. It accepts parallel words over a valid/ready handshake and serializes them MSB-first, one bit per cycle. Each bit is fed to a pattern matcher that detects overlapping occurrences of a programmable pattern. It counts matches and ends a run on a match target, a timeout or an abort. It sits between a word-oriented producer and status logic that needs detection counts.

Parameters:
WORD_W, 8, input word width (bits serialized per word)
PAT_MAX, 8, maximum pattern length in bits
CNT_W, 8, match counter width
TO_W, 16, timeout counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; arms a run; ignored while busy
abort  in  1  pulse; cancels the run
cfg_pattern  in  PAT_MAX  pattern; bit [cfg_len-1] is compared against the oldest bit
cfg_len  in  $clog2(PAT_MAX)+1  pattern length; 0 is treated as 1, >PAT_MAX as PAT_MAX
cfg_target  in  CNT_W  matches that end the run; 0 = no count limit
cfg_timeout  in  TO_W  busy cycles without a match before timeout; 0 = disabled
in_valid  in  1  word valid
in_ready  out  1  word accepted when in_valid&&in_ready
in_data  in  WORD_W  word
bit_valid  out  1  serialized bit present this cycle
bit_out  out  1  serialized bit
match_pulse  out  1  one-cycle pulse per match
match_cnt  out  CNT_W  matches in the current/last run; saturates at all-ones
busy  out  1  run in progress
done  out  1  one-cycle pulse at normal or timeout end
timeout_flag  out  1  last run ended by timeout

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low; all state and outputs are 0 in reset (FSM in IDLE).
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: on start, latch the cfg_* inputs, clear the history, fill count, match_cnt, timeout counter and timeout_flag, then go to LOAD.
  - LOAD: in_ready=1. On handshake, latch in_data, set the bit index to WORD_W-1 and go to SHIFT. No handshake: stay in LOAD.
  - SHIFT: bit_valid=1 and bit_out=word[idx]. On each edge, decrement idx. After idx 0, go back to LOAD.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in LOAD and SHIFT only. in_ready=0 in every state except LOAD, so a word is never accepted in the same cycle as a bit shift.
- Matcher: the history shift register persists across words within a run, so patterns may straddle words and stalls.
  - hit = bit_valid && fill>=len && history[len-1:0]==pattern[len-1:0], where the history includes the current bit.
  - Overlapping matches count.
  - fill saturates at PAT_MAX.
- match_pulse is registered and asserts in the cycle after the hit bit. match_cnt updates on the same edge.
- Target reached: the edge that registers match number cfg_target (target≠0) moves the FSM to DONE. Remaining bits of the current word are discarded.
- Timeout: the counter increments every busy cycle and clears on hit. When it would reach cfg_timeout (≠0), go to DONE and set timeout_flag.
- Simultaneous events on one edge:
  - hit and timeout: the hit wins and the counter clears.
  - hit reaching target and last bit of the word: go to DONE, not LOAD.
- abort from any busy state or DONE: go to IDLE on the next edge. No done pulse; match_cnt and timeout_flag hold.
- Results: match_cnt and timeout_flag hold after the run until the next accepted start.
- Reset mid-run: immediate return to IDLE with all outputs 0. A partially shifted word is lost.
- Configuration: cfg_* changes during a run have no effect (latched at start).

Decomposition:
- Package seq_stream_pkg holds:
  - localparams for the FSM state encodings (IDLE=0, LOAD=1, SHIFT=2, DONE=3);
  - LEN_W=$clog2(PAT_MAX)+1;
  - the length clamp function.
- Sub-module seq_match_core contains the history register, the fill counter, the hit comparator and the registered match_pulse.
- seq_stream_ctrl holds the FSM, word register, bit index, match/timeout counters and handshake.

Test Plan:
1. Overlap and target: pattern=4'b1001, len=4, target=2; start, then word 8'h92 (bits 1,0,0,1,0,0,1,0) -> hits on bits 3 and 6; match_pulse twice; match_cnt=2; done one cycle after the 7th bit_valid; 8th bit not emitted; timeout_flag=0.
2. Cross-word with stall: pattern=4'b0011, target=1; words 8'h01, then in_valid held low 5 cycles, then 8'h80 -> in_ready high throughout the stall with no bit_valid; match on the first bit of the second word; match_cnt=1; done.
3. Timeout: pattern=4'b1111, timeout=20, target=0; continuous 8'h00 words -> no match_pulse; done and timeout_flag=1 on the 20th busy cycle after start; match_cnt=0.
4. Abort mid-shift: target=0; abort during the 3rd bit of a word -> busy=0 next cycle; done never asserts; match_cnt holds; a later start clears it to 0.
5. Reset and start guard: rst_n low during SHIFT -> all outputs 0 immediately; start pulses during busy are ignored (config unchanged).
6. Length clamp and saturation: cfg_len=0 with pattern bit0=1 and an 8'hFF stream, CNT_W=8, target=0 -> a match on every bit; match_cnt stops at 255.

Source files
------------

// File: rtl/seq_stream_pkg.sv
// Shared definitions for the serial stream controller: FSM encoding,
// default length width and the pattern-length clamp.
package seq_stream_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_e;

   localparam int PAT_MAX_DFLT = 8;
   localparam int LEN_W        = $clog2(PAT_MAX_DFLT) + 1;

   // A zero length still compares one bit; anything beyond the history depth is capped.
   function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
      if (len == 8'd0) return 8'd1;
      if (len > max_len) return max_len;
      return len;
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: bit history spanning words, fill tracking,
// masked comparison of the newest len bits and a registered match pulse.
module seq_match_core #(
   parameter int PAT_MAX = 8,
   parameter int LW      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               adv_i,
   input  logic               bit_i,
   input  logic [PAT_MAX-1:0] pattern_i,
   input  logic [LW-1:0]      len_i,
   output logic               hit_o,
   output logic               match_pulse_o
);

   logic [PAT_MAX-2:0] hist_q, hist_d;
   logic [PAT_MAX-1:0] hist_now, mask;
   logic [LW-1:0]      fill_q, fill_d;
   logic               pulse_q;

   always_comb begin
      hist_now = {hist_q, bit_i};
      mask     = '0;
      for (int i = 0; i < PAT_MAX; i++) mask[i] = (i < int'(len_i));
      // The current bit already sits in hist_now, so it counts towards the fill.
      hit_o = adv_i && (({1'b0, fill_q} + 1'b1) >= {1'b0, len_i}) &&
              (((hist_now ^ pattern_i) & mask) == '0);
      hist_d = hist_q;
      fill_d = fill_q;
      if (clr_i) begin
         hist_d = '0;
         fill_d = '0;
      end else if (adv_i) begin
         hist_d = hist_now[PAT_MAX-2:0];
         if (fill_q != LW'(PAT_MAX)) fill_d = fill_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q  <= '0;
         fill_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pulse_q <= hit_o;
      end
   end

   assign match_pulse_o = pulse_q;

endmodule

// File: rtl/seq_stream_ctrl.sv
// Stream controller: accepts words over valid/ready, shifts them MSB-first
// into the matcher and ends a run on match target, timeout or abort.
module seq_stream_ctrl
   import seq_stream_pkg::*;
#(
   parameter int WORD_W  = 8,
   parameter int PAT_MAX = 8,
   parameter int CNT_W   = 8,
   parameter int TO_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [PAT_MAX-1:0]       cfg_pattern,
   input  logic [$clog2(PAT_MAX):0] cfg_len,
   input  logic [CNT_W-1:0]         cfg_target,
   input  logic [TO_W-1:0]          cfg_timeout,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WORD_W-1:0]        in_data,
   output logic                     bit_valid,
   output logic                     bit_out,
   output logic                     match_pulse,
   output logic [CNT_W-1:0]         match_cnt,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout_flag
);

   localparam int LW = $clog2(PAT_MAX) + 1;
   localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   state_e             state_q, state_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [PAT_MAX-1:0] pat_q, pat_d;
   logic [LW-1:0]      len_q, len_d;
   logic [CNT_W-1:0]   tgt_q, tgt_d, cnt_q, cnt_d;
   logic [TO_W-1:0]    tmo_q, tmo_d, tcnt_q, tcnt_d;
   logic               tflag_q, tflag_d;
   logic               shifting, running, adv, clr, hit;
   logic [CNT_W:0]     cnt_inc;
   logic [TO_W:0]      tcnt_inc;

   assign shifting = (state_q == SHIFT);
   assign running  = (state_q == LOAD) || shifting;
   // An aborting edge must not register a match.
   assign adv      = shifting && !abort;
   assign clr      = (state_q == IDLE) && start;
   assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
   assign tcnt_inc = {1'b0, tcnt_q} + 1'b1;

   seq_match_core #(.PAT_MAX(PAT_MAX), .LW(LW)) u_core (
      .clk           (clk),
      .rst_n         (rst_n),
      .clr_i         (clr),
      .adv_i         (adv),
      .bit_i         (word_q[idx_q]),
      .pattern_i     (pat_q),
      .len_i         (len_q),
      .hit_o         (hit),
      .match_pulse_o (match_pulse)
   );

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      pat_d   = pat_q;
      len_d   = len_q;
      tgt_d   = tgt_q;
      tmo_d   = tmo_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      tflag_d = tflag_q;
      unique case (state_q)
         IDLE: if (start) begin
            pat_d   = cfg_pattern;
            len_d   = LW'(clamp_len(8'(cfg_len), 8'(PAT_MAX)));
            tgt_d   = cfg_target;
            tmo_d   = cfg_timeout;
            cnt_d   = '0;
            tcnt_d  = '0;
            tflag_d = 1'b0;
            state_d = LOAD;
         end
         LOAD: if (in_valid) begin
            word_d  = in_data;
            idx_d   = IW'(WORD_W - 1);
            state_d = SHIFT;
         end
         SHIFT: begin
            idx_d = idx_q - 1'b1;
            if (idx_q == '0) state_d = LOAD;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Run-end conditions override the word sequencing; a hit always beats the timeout.
      if (running) begin
         if (hit) begin
            tcnt_d = '0;
            if (!cnt_inc[CNT_W]) cnt_d = cnt_inc[CNT_W-1:0];
            if (tgt_q != '0 && cnt_inc == {1'b0, tgt_q}) state_d = DONE;
         end else begin
            tcnt_d = tcnt_inc[TO_W-1:0];
            if (tmo_q != '0 && tcnt_inc == {1'b0, tmo_q}) begin
               state_d = DONE;
               tflag_d = 1'b1;
            end
         end
      end
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = cnt_q;
         tcnt_d  = tcnt_q;
         tflag_d = tflag_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         tgt_q   <= '0;
         tmo_q   <= '0;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         tflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         tgt_q   <= tgt_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         tflag_q <= tflag_d;
      end
   end

   assign in_ready     = (state_q == LOAD);
   assign bit_valid    = shifting;
   assign bit_out      = shifting & word_q[idx_q];
   assign busy         = running;
   assign done         = (state_q == DONE);
   assign match_cnt    = cnt_q;
   assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Self-checking bench for seq_stream_ctrl: directed scenarios plus random
// traffic compared each cycle against a bit-queue reference model.
module tb_seq_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [7:0]  cfg_pattern = '0, cfg_target = '0, in_data = '0;
   logic [3:0]  cfg_len = '0;
   logic [15:0] cfg_timeout = '0;
   logic        in_ready, bit_valid, bit_out, match_pulse, busy, done, timeout_flag;
   logic [7:0]  match_cnt;

   seq_stream_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(8), .TO_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
      .cfg_timeout(cfg_timeout), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .bit_valid(bit_valid), .bit_out(bit_out),
      .match_pulse(match_pulse), .match_cnt(match_cnt), .busy(busy),
      .done(done), .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: run phase, current word/bit position, history as a queue (newest first).
   localparam int M_IDLE = 0, M_LOAD = 1, M_SHIFT = 2, M_DONE = 3;
   int       m_st, m_pos, m_len, m_tgt, m_tmo, m_cnt, m_tc;
   bit [7:0] m_word, m_pat;
   bit       m_tf, m_pulse;
   bit       m_hist[$];

   function automatic void model_reset();
      m_st = M_IDLE; m_pos = 0; m_len = 0; m_tgt = 0; m_tmo = 0; m_cnt = 0; m_tc = 0;
      m_word = '0; m_pat = '0; m_tf = 1'b0; m_pulse = 1'b0;
      m_hist.delete();
   endfunction

   function automatic void model_step();
      bit hit = 1'b0;
      int nst = m_st;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_st != M_IDLE && abort) begin
         m_st = M_IDLE;
         m_pulse = 1'b0;
         return;
      end
      case (m_st)
         M_IDLE: if (start) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 0) ? 1 : ((cfg_len > 8) ? 8 : int'(cfg_len));
            m_tgt = int'(cfg_target);
            m_tmo = int'(cfg_timeout);
            m_cnt = 0; m_tc = 0; m_tf = 1'b0;
            m_hist.delete();
            nst = M_LOAD;
         end
         M_LOAD: if (in_valid) begin
            m_word = in_data; m_pos = 7; nst = M_SHIFT;
         end
         M_SHIFT: begin
            m_hist.push_front(m_word[m_pos]);
            if (m_hist.size() > 8) void'(m_hist.pop_back());
            if (m_hist.size() >= m_len) begin
               hit = 1'b1;
               for (int k = 0; k < m_len; k++) if (m_hist[k] != m_pat[k]) hit = 1'b0;
            end
            if (m_pos == 0) nst = M_LOAD; else m_pos--;
         end
         default: nst = M_IDLE;
      endcase
      if (m_st == M_LOAD || m_st == M_SHIFT) begin
         if (hit) begin
            m_tc = 0;
            if (m_tgt != 0 && m_cnt + 1 == m_tgt) nst = M_DONE;
            if (m_cnt < 255) m_cnt++;
         end else begin
            m_tc++;
            if (m_tmo != 0 && m_tc == m_tmo) begin nst = M_DONE; m_tf = 1'b1; end
         end
      end
      m_pulse = hit;
      m_st = nst;
   endfunction

   task automatic compare_all();
      chk("busy",         32'(busy),         32'(m_st == M_LOAD || m_st == M_SHIFT));
      chk("in_ready",     32'(in_ready),     32'(m_st == M_LOAD));
      chk("bit_valid",    32'(bit_valid),    32'(m_st == M_SHIFT));
      chk("bit_out",      32'(bit_out),      32'((m_st == M_SHIFT) ? m_word[m_pos] : 1'b0));
      chk("done",         32'(done),         32'(m_st == M_DONE));
      chk("match_pulse",  32'(match_pulse),  32'(m_pulse));
      chk("match_cnt",    32'(match_cnt),    32'(m_cnt));
      chk("timeout_flag", 32'(timeout_flag), 32'(m_tf));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t,
                          input logic [15:0] to);
      cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_timeout = to;
   endtask

   task automatic idle_gap();
      start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      cyc(); cyc();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_bit_valid", 32'(bit_valid), 0);
      chk("rst_bit_out", 32'(bit_out), 0);
      chk("rst_match_pulse", 32'(match_pulse), 0);
      chk("rst_match_cnt", 32'(match_cnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_timeout_flag", 32'(timeout_flag), 0);
      model_reset();
      cyc(); cyc();
      rst_n = 1'b1;
   endtask

   int c_bv, c_mp, c_busy;
   bit got_done;

   task automatic run_until_done(input int maxc);
      c_bv = 0; c_mp = 0; c_busy = 0; got_done = 1'b0;
      for (int i = 0; i < maxc && !got_done; i++) begin
         cyc();
         start = 1'b0;
         c_bv += int'(bit_valid);
         c_mp += int'(match_pulse);
         c_busy += int'(busy);
         if (done) got_done = 1'b1;
      end
      chk("done_seen", 32'(got_done), 1);
   endtask

   task automatic rand_cycle();
      start    = ($urandom_range(0, 9) == 0);
      abort    = ($urandom_range(0, 60) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
         set_cfg(8'($urandom), 4'($urandom_range(0, 12)), 8'($urandom_range(0, 5)),
                 ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(5, 40)));
      cyc();
   endtask

   initial begin
      model_reset();
      cyc(); cyc();
      chk("por_busy", 32'(busy), 0);
      chk("por_done", 32'(done), 0);
      rst_n = 1'b1;
      cyc();

      // Overlapping matches with a target of two inside one word.
      set_cfg(8'h09, 4'd4, 8'd2, 16'd0);
      in_valid = 1'b1; in_data = 8'h92; start = 1'b1;
      run_until_done(20);
      chk("t1_bits", 32'(c_bv), 7);
      chk("t1_pulses", 32'(c_mp), 2);
      chk("t1_cnt", 32'(match_cnt), 2);
      chk("t1_tflag", 32'(timeout_flag), 0);
      idle_gap();

      // Pattern straddling two words separated by a producer stall.
      set_cfg(8'h03, 4'd4, 8'd1, 16'd0);
      start = 1'b1; cyc(); start = 1'b0;
      in_valid = 1'b1; in_data = 8'h01; cyc();
      in_valid = 1'b0;
      repeat (8) cyc();
      for (int i = 0; i < 5; i++) begin
         chk("t2_stall_rdy", 32'(in_ready), 1);
         chk("t2_stall_bv", 32'(bit_valid), 0);
         cyc();
      end
      in_valid = 1'b1; in_data = 8'h80;
      run_until_done(20);
      chk("t2_bits", 32'(c_bv), 1);
      chk("t2_pulses", 32'(c_mp), 1);
      chk("t2_cnt", 32'(match_cnt), 1);
      idle_gap();

      // Timeout after twenty busy cycles with no match.
      set_cfg(8'h0F, 4'd4, 8'd0, 16'd20);
      in_valid = 1'b1; in_data = 8'h00; start = 1'b1;
      run_until_done(40);
      chk("t3_busy_cycles", 32'(c_busy), 20);
      chk("t3_pulses", 32'(c_mp), 0);
      chk("t3_tflag", 32'(timeout_flag), 1);
      chk("t3_cnt", 32'(match_cnt), 0);
      idle_gap();

      // Abort on the third bit keeps the count and emits no done.
      set_cfg(8'h01, 4'd1, 8'd0, 16'd0);
      in_valid = 1'b1; in_data = 8'hFF;
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
      in_valid = 1'b0;
      cyc(); cyc();
      abort = 1'b1; cyc(); abort = 1'b0;
      chk("t4_busy", 32'(busy), 0);
      chk("t4_cnt", 32'(match_cnt), 2);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t4_no_done", 32'(done), 0);
      end
      start = 1'b1; cyc(); start = 1'b0;
      chk("t4_cnt_cleared", 32'(match_cnt), 0);
      abort = 1'b1; cyc(); abort = 1'b0;
      idle_gap();

      // Start pulses while busy are ignored; reset mid-shift clears everything.
      set_cfg(8'h05, 4'd3, 8'd0, 16'd0);
      start = 1'b1; cyc(); start = 1'b0;
      in_valid = 1'b1; in_data = 8'hA5; cyc();
      set_cfg(8'h01, 4'd1, 8'd1, 16'd3);
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 12; i++) begin in_data = 8'($urandom); cyc(); end
      for (int i = 0; i < 20 && !bit_valid; i++) cyc();
      chk("t5_in_shift", 32'(bit_valid), 1);
      do_reset();
      idle_gap();

      // Length 0 behaves as 1; count saturates at 255.
      set_cfg(8'h01, 4'd0, 8'd0, 16'd0);
      in_valid = 1'b1; in_data = 8'hFF;
      start = 1'b1; cyc(); start = 1'b0;
      repeat (320) cyc();
      chk("t6_cnt_sat", 32'(match_cnt), 255);
      abort = 1'b1; cyc(); abort = 1'b0;
      idle_gap();

      // Random traffic with occasional asynchronous resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         else rand_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
